// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch/decode shared types and word-alignment helper
package fetch_unit_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } FetchEntry;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem request/response, redirect and decode handshake bundle
interface fetch_unit_if #(
    parameter int FB_DEPTH = 4
);
    logic                      OUT_imemEn;
    logic [31:0]               OUT_imemAddr;
    logic [31:0]               IN_imemData;
    logic                      IN_branchTaken;
    logic [31:0]               IN_branchAddr;
    logic                      IN_ready;
    logic                      OUT_valid;
    logic [31:0]               OUT_instr;
    logic [31:0]               OUT_pc;
    logic [$clog2(FB_DEPTH):0] OUT_fbCount;

    modport master (
        output OUT_imemEn, OUT_imemAddr, OUT_valid, OUT_instr, OUT_pc, OUT_fbCount,
        input  IN_imemData, IN_branchTaken, IN_branchAddr, IN_ready
    );

    modport slave (
        input  OUT_imemEn, OUT_imemAddr, OUT_valid, OUT_instr, OUT_pc, OUT_fbCount,
        output IN_imemData, IN_branchTaken, IN_branchAddr, IN_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular FIFO of FetchEntry with flush; count separates full from empty
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  FetchEntry     push_data_i,
    input  logic          pop_i,
    output FetchEntry     head_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);

    FetchEntry       mem_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            // The upstream credit check must make a push into a full buffer impossible.
            if (push_i && !pop_i && !flush_i)
                assert (count_q < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_i && !flush_i)
            mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding imem request, credit check and redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(FB_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          issue, push, pop, head_valid;
    logic [CW-1:0] count;
    FetchEntry     head, push_entry;

    // Credit counts the in-flight request so its response always has a free slot.
    assign issue      = rst & ~bus.IN_branchTaken & ((count + CW'(inflight_q)) < CW'(FB_DEPTH));
    assign push       = inflight_q & ~bus.IN_branchTaken;
    assign head_valid = rst & (count != '0);
    assign pop        = head_valid & bus.IN_ready;
    assign push_entry = '{pc: req_pc_q, instr: bus.IN_imemData};

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        if (bus.IN_branchTaken) begin
            pc_d = align_word(bus.IN_branchAddr);
        end else if (issue) begin
            pc_d     = pc_q + 32'(INSTR_BYTES);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_buffer #(
        .DEPTH (FB_DEPTH),
        .CW    (CW)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.IN_branchTaken),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.OUT_imemEn   = issue;
    assign bus.OUT_imemAddr = pc_q;
    assign bus.OUT_valid    = head_valid;
    assign bus.OUT_instr    = head.instr;
    assign bus.OUT_pc       = head.pc;
    assign bus.OUT_fbCount  = rst ? count : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench: expected PCs queued by stimulus, popped by monitors
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_w;

    fetch_unit_if #(.FB_DEPTH(4)) bus ();
    fetch_unit_if #(.FB_DEPTH(4)) bus_w ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FB_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FB_DEPTH(4)) u_wrap (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w.master)
    );

    int          checks   = 0;
    int          failures = 0;
    int          acc_cnt  = 0;
    int          acc_w    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_w [$];
    logic [31:0] e_m, e_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory: returns the requested address as data one cycle later.
    always @(posedge clk) begin
        bus.IN_imemData   <= bus.OUT_imemEn   ? bus.OUT_imemAddr   : 32'hDEAD_BEEF;
        bus_w.IN_imemData <= bus_w.OUT_imemEn ? bus_w.OUT_imemAddr : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (rst && bus.OUT_valid && bus.IN_ready && !bus.IN_branchTaken) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_entry: got pc %h expected no entry", bus.OUT_pc);
            end else begin
                e_m = exp_q.pop_front();
                check("entry_pc", bus.OUT_pc, e_m);
                check("entry_instr", bus.OUT_instr, e_m);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_w && bus_w.OUT_valid && bus_w.IN_ready) begin
            acc_w++;
            if (exp_w.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wrap_unexpected_entry: got pc %h expected no entry", bus_w.OUT_pc);
            end else begin
                e_w = exp_w.pop_front();
                check("wrap_pc", bus_w.OUT_pc, e_w);
                check("wrap_instr", bus_w.OUT_instr, e_w);
            end
        end
    end

    // Called just after a posedge; leaves exactly n more entries accepted.
    task automatic wait_accepts(input int n, input bit keep);
        int target;
        int cyc;
        target = acc_cnt + n;
        cyc = 0;
        bus.IN_ready = 1'b1;
        while (acc_cnt < target && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!keep) bus.IN_ready = 1'b0;
        check("accept_count", 32'(acc_cnt), 32'(target));
    endtask

    task automatic reset_main();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        int cyc;
        rst = 1'b0;
        rst_w = 1'b0;
        bus.IN_ready = 1'b1;
        bus.IN_branchTaken = 1'b0;
        bus.IN_branchAddr = '0;
        bus_w.IN_ready = 1'b0;
        bus_w.IN_branchTaken = 1'b0;
        bus_w.IN_branchAddr = '0;

        // 1: reset state, release latency, in-order stream
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_imemEn", 32'(bus.OUT_imemEn), 0);
            check("rst_valid", 32'(bus.OUT_valid), 0);
            check("rst_fbCount", 32'(bus.OUT_fbCount), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        check("t1_c0_valid", 32'(bus.OUT_valid), 0);
        check("t1_c0_imemEn", 32'(bus.OUT_imemEn), 1);
        check("t1_c0_addr", bus.OUT_imemAddr, 32'h0);
        @(negedge clk);
        check("t1_c1_valid", 32'(bus.OUT_valid), 0);
        @(negedge clk);
        check("t1_c2_valid", 32'(bus.OUT_valid), 1);
        @(posedge clk);
        #1;
        wait_accepts(9, 1'b0);
        check("t1_drained", 32'(exp_q.size()), 0);

        // 2: backpressure from reset
        bus.IN_ready = 1'b0;
        reset_main();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.OUT_imemEn) n_req++;
        end
        check("t2_requests", 32'(n_req), 4);
        check("t2_fbCount", 32'(bus.OUT_fbCount), 4);
        check("t2_imemEn", 32'(bus.OUT_imemEn), 0);
        check("t2_pc_held", bus.OUT_imemAddr, 32'h10);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
        wait_accepts(6, 1'b0);
        check("t2_drained", 32'(exp_q.size()), 0);

        // 3: redirect with a request in flight
        reset_main();
        @(posedge clk);
        #1;
        bus.IN_branchTaken = 1'b1;
        bus.IN_branchAddr = 32'h103;
        @(negedge clk);
        check("t3_no_issue_on_redirect", 32'(bus.OUT_imemEn), 0);
        @(posedge clk);
        #1;
        bus.IN_branchTaken = 1'b0;
        @(negedge clk);
        check("t3_t1_imemEn", 32'(bus.OUT_imemEn), 1);
        check("t3_t1_addr", bus.OUT_imemAddr, 32'h100);
        check("t3_t1_valid", 32'(bus.OUT_valid), 0);
        @(negedge clk);
        check("t3_t2_valid", 32'(bus.OUT_valid), 0);
        @(negedge clk);
        check("t3_t3_valid", 32'(bus.OUT_valid), 1);
        check("t3_t3_pc", bus.OUT_pc, 32'h100);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        wait_accepts(3, 1'b0);
        check("t3_drained", 32'(exp_q.size()), 0);

        // 4: redirect coinciding with push and pop
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_full", 32'(bus.OUT_fbCount), 4);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h10C + 32'(4 * i));
        wait_accepts(6, 1'b1);
        bus.IN_branchTaken = 1'b1;
        bus.IN_branchAddr = 32'h200;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        @(negedge clk);
        check("t4_pre_count", 32'(bus.OUT_fbCount), 2);
        check("t4_pre_valid", 32'(bus.OUT_valid), 1);
        @(posedge clk);
        #1;
        bus.IN_branchTaken = 1'b0;
        @(negedge clk);
        check("t4_post_count", 32'(bus.OUT_fbCount), 0);
        check("t4_post_valid", 32'(bus.OUT_valid), 0);
        @(posedge clk);
        #1;
        wait_accepts(2, 1'b0);
        check("t4_drained", 32'(exp_q.size()), 0);

        // 6: one-cycle reset with 3 entries queued and a fetch in flight
        bus.IN_branchTaken = 1'b1;
        bus.IN_branchAddr = 32'h300;
        @(posedge clk);
        #1;
        bus.IN_branchTaken = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_count3", 32'(bus.OUT_fbCount), 3);
        check("t6_no_issue", 32'(bus.OUT_imemEn), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_valid_after_rst", 32'(bus.OUT_valid), 0);
        check("t6_count_after_rst", 32'(bus.OUT_fbCount), 0);
        check("t6_restart_addr", bus.OUT_imemAddr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        @(posedge clk);
        #1;
        wait_accepts(3, 1'b0);
        check("t6_drained", 32'(exp_q.size()), 0);

        // 5: PC wrap on the second instance
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        bus_w.IN_ready = 1'b1;
        exp_w.push_back(32'hFFFF_FFF8);
        exp_w.push_back(32'hFFFF_FFFC);
        exp_w.push_back(32'h0000_0000);
        exp_w.push_back(32'h0000_0004);
        cyc = 0;
        while (acc_w < 4 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_w.IN_ready = 1'b0;
        check("t5_accepts", 32'(acc_w), 4);
        check("t5_drained", 32'(exp_w.size()), 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
